// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and constants for the req/ack clock-domain-crossing
// handshake endpoints.
//   state_e            - destination-side FSM state encoding (IDLE/HOLD/ACK)
//   SYNC_STAGES_MIN/MAX - legal range of synchronizer depth
`timescale 1ns/1ps
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop synchronizer for a single asynchronous level.
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage
//   d   - asynchronous input level
//   q   - synchronized level (last stage), STAGES edges behind d
`timescale 1ns/1ps
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: destination endpoint of the four-phase req/ack handshake,
// clocked entirely by clkb.
//   clkb, rstb       - destination clock, asynchronous active-high reset
//   req_a, data_a    - request level and data from the source domain
//   ack_b            - registered acknowledge level back to the source
//   out_valid/out_data/out_ready - downstream valid/ready interface
//   busy             - FSM not in IDLE
//   xfer_cnt         - completed transfers, wraps silently
//   proto_err        - sticky: source dropped req_a before ack_b was raised
`timescale 1ns/1ps
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clkb,
  input  logic             rstb,
  input  logic             req_a,
  input  logic [DW-1:0]    data_a,
  output logic             ack_b,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("cdc_hs_rx: SYNC_STAGES out of legal range");
  end

  logic req_s;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clkb),
    .rst (rstb),
    .d   (req_a),
    .q   (req_s)
  );

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        // data_a is sampled raw: the source holds it stable while req_a is up
        if (req_s) begin
          data_d  = data_a;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // early request drop is only flagged; the handshake still completes
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack_b     = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = (state_q != ST_IDLE);
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
`timescale 1ns/100ps
module tb_cdc_hs_rx;

  logic       clkb;
  logic       rstb;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_b;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [3:0] xfer_cnt;
  logic       proto_err;

  int total;
  int bad;
  logic [3:0] exp_cnt;

  cdc_hs_rx #(
    .DW          (8),
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut (
    .clkb      (clkb),
    .rstb      (rstb),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_b     (ack_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err)
  );

  initial clkb = 1'b0;
  always #1.5 clkb = ~clkb;

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic cyc();
    @(negedge clkb);
  endtask

  task automatic test_reset();
    rstb = 1'b0; req_a = 1'b0; data_a = 8'h00; out_ready = 1'b0;
    #1 rstb = 1'b1;
    cyc(); cyc();
    total++; if (ack_b !== 1'b0)     begin bad++; $display("FAIL reset_ack got=%b exp=0", ack_b); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (xfer_cnt !== 4'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", proto_err); end
    rstb = 1'b0;
    exp_cnt = 4'd0;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1; data_a = 8'hA5; req_a = 1'b1;
    cyc(); cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b exp=0", out_valid); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", out_data); end
    total++; if (ack_b !== 1'b0)     begin bad++; $display("FAIL basic_ack_early got=%b exp=0", ack_b); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    cyc();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    total++; if (ack_b !== 1'b1)     begin bad++; $display("FAIL basic_ack_rise got=%b exp=1", ack_b); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL basic_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    cyc(); cyc();
    total++; if (ack_b !== 1'b1)     begin bad++; $display("FAIL basic_ack_held got=%b exp=1", ack_b); end
    req_a = 1'b0;
    cyc(); cyc();
    total++; if (ack_b !== 1'b1)     begin bad++; $display("FAIL basic_ack_fall_early got=%b exp=1", ack_b); end
    cyc();
    total++; if (ack_b !== 1'b0)     begin bad++; $display("FAIL basic_ack_fall got=%b exp=0", ack_b); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL basic_idle got=%b exp=0", busy); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL basic_data_kept got=%h exp=a5", out_data); end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; data_a = 8'h5A; req_a = 1'b1;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || ack_b !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h a=%b exp v=1 d=5a a=0", i, out_valid, out_data, ack_b);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (ack_b !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_accept got a=%b v=%b exp a=1 v=0", ack_b, out_valid);
    end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL bp_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    req_a = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (ack_b !== 1'b0) begin bad++; $display("FAIL bp_ack_fall got=%b exp=0", ack_b); end
    cyc();
  endtask

  task automatic test_data_change();
    out_ready = 1'b0; data_a = 8'hA5; req_a = 1'b1;
    cyc(); cyc(); cyc();
    data_a = 8'h3C;
    cyc(); cyc(); cyc();
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL dchg_hold got=%h exp=a5", out_data); end
    out_ready = 1'b1;
    cyc();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_data !== 8'hA5 || ack_b !== 1'b1) begin
      bad++; $display("FAIL dchg_accept got d=%h a=%b exp d=a5 a=1", out_data, ack_b);
    end
    req_a = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (out_data !== 8'hA5 || busy !== 1'b0) begin
      bad++; $display("FAIL dchg_after got d=%h busy=%b exp d=a5 busy=0", out_data, busy);
    end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL dchg_err got=%b exp=0", proto_err); end
    cyc();
  endtask

  task automatic test_proto_err();
    out_ready = 1'b0; data_a = 8'hC3;
    #0.5 req_a = 1'b1;
    #4.5 req_a = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_flag got=%b exp=1", proto_err); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || ack_b !== 1'b0) begin
      bad++; $display("FAIL perr_hold got v=%b d=%h a=%b exp v=1 d=c3 a=0", out_valid, out_data, ack_b);
    end
    out_ready = 1'b1;
    cyc();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (ack_b !== 1'b1 || xfer_cnt !== exp_cnt) begin
      bad++; $display("FAIL perr_accept got a=%b cnt=%0d exp a=1 cnt=%0d", ack_b, xfer_cnt, exp_cnt);
    end
    cyc();
    total++; if (ack_b !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL perr_idle got a=%b busy=%b exp a=0 busy=0", ack_b, busy);
    end
    cyc(); cyc();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; data_a = 8'h77; req_a = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    total++; if (ack_b !== 1'b1) begin bad++; $display("FAIL rmid_in_ack got=%b exp=1", ack_b); end
    #0.5 rstb = 1'b1;
    #0.1;
    total++; if (ack_b !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 ||
                 xfer_cnt !== 4'd0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL rmid_async got a=%b v=%b d=%h b=%b c=%0d e=%b exp all zero",
                      ack_b, out_valid, out_data, busy, xfer_cnt, proto_err);
    end
    exp_cnt = 4'd0;
    cyc();
    rstb = 1'b0;
    cyc(); cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_early got=%b exp=0", out_valid); end
    cyc();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      bad++; $display("FAIL rmid_recapture got v=%b d=%h exp v=1 d=77", out_valid, out_data);
    end
    cyc();
    exp_cnt = exp_cnt + 4'd1;
    req_a = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (ack_b !== 1'b0 || xfer_cnt !== exp_cnt) begin
      bad++; $display("FAIL rmid_done got a=%b cnt=%0d exp a=0 cnt=%0d", ack_b, xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    rstb = 1'b1;
    cyc();
    rstb = 1'b0;
    exp_cnt = 4'd0;
    out_ready = 1'b1;
    for (int t = 0; t < 17; t++) begin
      data_a = 8'(t + 1);
      req_a = 1'b1;
      for (int k = 0; k < 20 && ack_b !== 1'b1; k++) cyc();
      exp_cnt = exp_cnt + 4'd1;
      total++; if (ack_b !== 1'b1 || xfer_cnt !== exp_cnt) begin
        bad++; $display("FAIL wrap_ack t=%0d got a=%b cnt=%0d exp a=1 cnt=%0d", t, ack_b, xfer_cnt, exp_cnt);
      end
      req_a = 1'b0;
      for (int k = 0; k < 20 && ack_b !== 1'b0; k++) cyc();
      total++; if (ack_b !== 1'b0) begin bad++; $display("FAIL wrap_release t=%0d got=%b exp=0", t, ack_b); end
      cyc();
    end
    total++; if (xfer_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", xfer_cnt); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", proto_err); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 4'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_data_change();
    test_proto_err();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
